// File: rtl/uart_tx_framer_pkg.sv
// Shared UART definitions: frame geometry, bit positions and transmit FSM states.
package uart_tx_framer_pkg;

   localparam int FRAME_W   = 11;
   localparam int DATA_W    = 8;
   localparam int START_IDX = 0;
   localparam int PAR_IDX   = 9;
   localparam int STOP_IDX  = 10;

   // Index of the last serial bit in a frame, sized to match the bit counter
   localparam logic [3:0] LAST_BIT = 4'(STOP_IDX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] baud_cnt;

   // Count cycles within a bit; the wrap is an explicit compare, and clear parks the counter at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (clear || (baud_cnt == LAST_CNT)) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CNT_W'(1);
      end
   end

   assign bit_tick = !clear && (baud_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: latches a byte, frames it as start/data/parity/stop and shifts it out LSB first.
module uart_tx_framer
   import uart_tx_framer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] data_in,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   tx_state_t          state;
   tx_state_t          state_next;
   logic [FRAME_W-1:0] shift_reg;
   logic [FRAME_W-1:0] shift_next;
   logic [FRAME_W-1:0] frame;
   logic [3:0]         bit_cnt;
   logic [3:0]         bit_cnt_next;
   logic               parity_bit;
   logic               bit_tick;
   logic               baud_clear;
   logic               tx_out_next;
   logic               tx_busy_next;
   logic               tx_done_next;

   assign parity_bit = (PARITY_ODD != 0) ? ~^data_in : ^data_in;

   // The baud counter only runs while a frame is on the line, so every frame starts on a fresh bit period
   assign baud_clear = (state != SEND);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) baud_gen (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .bit_tick(bit_tick)
   );

   // Assemble the frame that gets latched on the accepting edge
   always_comb begin
      frame              = '0;
      frame[START_IDX]   = 1'b0;
      frame[DATA_W:1]    = data_in;
      frame[PAR_IDX]     = parity_bit;
      frame[STOP_IDX]    = 1'b1;
   end

   // State register together with the shift register and bit counter it steers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
      end
   end

   // Next-state logic: accept from IDLE or DONE, shift on each bit tick, finish after the stop bit
   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      case (state)
         IDLE, DONE: begin
            if (tx_start) begin
               state_next   = SEND;
               shift_next   = frame;
               bit_cnt_next = '0;
            end else begin
               state_next = IDLE;
            end
         end
         SEND: begin
            if (bit_tick) begin
               if (bit_cnt == LAST_BIT) begin
                  state_next = DONE;
               end else begin
                  shift_next   = {1'b1, shift_reg[FRAME_W-1:1]};
                  bit_cnt_next = bit_cnt + 4'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state, so the registered outputs line up with that state
   always_comb begin
      tx_out_next  = 1'b1;
      tx_busy_next = 1'b0;
      tx_done_next = 1'b0;
      case (state_next)
         SEND: begin
            tx_out_next  = shift_next[0];
            tx_busy_next = 1'b1;
         end
         DONE: begin
            tx_done_next = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers; reset drives the line back to idle-high at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_out  <= tx_out_next;
         tx_busy <= tx_busy_next;
         tx_done <= tx_done_next;
      end
   end

endmodule
